// File: rtl/thermo_pkg.sv
// Shared types and helpers for the thermometer peak meter.
// Peak FSM encodings and a constant log2 used to size counters.
package thermo_pkg;

   typedef enum logic [1:0] {
      TRACK = 2'd0,
      HOLD  = 2'd1,
      DECAY = 2'd2
   } pk_state_e;

   // Ceiling log2; 0 for v <= 1 (callers clamp to 1 bit).
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < v) r++;
      end
      return r;
   endfunction

endpackage

// File: rtl/thermo_peak_meter_if.sv
// Sample-in / display-out bundle of the peak meter.
// master: en, sample_valid, level, mode out; d_out, peak, clip in.
interface thermo_peak_meter_if #(
   parameter int LEVEL_W = 3,
   parameter int SEGS    = 7
);
   logic               en;
   logic               sample_valid;
   logic [LEVEL_W-1:0] level;
   logic               mode;
   logic [SEGS-1:0]    d_out;
   logic [LEVEL_W-1:0] peak;
   logic               clip;

   modport master (
      output en, sample_valid, level, mode,
      input  d_out, peak, clip
   );

   modport slave (
      input  en, sample_valid, level, mode,
      output d_out, peak, clip
   );
endinterface

// File: rtl/thermo_decode.sv
// Level to segment mask: bar (bits below lvl) or dot (bit lvl-1).
// lvl_i level, mode_i 0 bar / 1 dot, mask_o segment mask.
module thermo_decode #(
   parameter int LEVEL_W = 3,
   parameter int SEGS    = 7
) (
   input  logic [LEVEL_W-1:0] lvl_i,
   input  logic               mode_i,
   output logic [SEGS-1:0]    mask_o
);

   always_comb begin
      mask_o = '0;
      for (int i = 0; i < SEGS; i++) begin
         if (mode_i)
            mask_o[i] = (lvl_i == LEVEL_W'(i + 1));
         else
            mask_o[i] = (lvl_i > LEVEL_W'(i));
      end
   end

endmodule

// File: rtl/thermo_peak_meter.sv
// Bar/dot level meter with peak-hold marker that holds, then decays.
// clk, rst (sync, active high); bus: sample in, d_out/peak/clip out.
module thermo_peak_meter
   import thermo_pkg::*;
#(
   parameter int LEVEL_W   = 3,
   parameter int SEGS      = 7,
   parameter int HOLD_CYC  = 8,
   parameter int DECAY_CYC = 4
) (
   input logic                clk,
   input logic                rst,
   thermo_peak_meter_if.slave bus
);

   localparam int HW = (clog2(HOLD_CYC) < 1) ? 1 : clog2(HOLD_CYC);
   localparam int DW = (clog2(DECAY_CYC) < 1) ? 1 : clog2(DECAY_CYC);
   localparam logic [LEVEL_W-1:0] SEGS_L = LEVEL_W'(SEGS);
   localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_CYC - 1);
   localparam logic [DW-1:0] DEC_LD  = DW'(DECAY_CYC - 1);
   localparam logic [LEVEL_W:0] ONE  = (LEVEL_W + 1)'(1);

   logic [LEVEL_W-1:0] lvl_q, lvl_d;
   logic [LEVEL_W-1:0] peak_q, peak_d;
   logic [HW-1:0]      hold_q, hold_d;
   logic [DW-1:0]      dec_q, dec_d;
   pk_state_e          st_q, st_d;
   logic               clip_q, clip_d;

   logic               cap;
   logic               over;
   logic [LEVEL_W-1:0] s;
   logic [SEGS-1:0]    base_m, peak_m;

   assign cap  = bus.en & bus.sample_valid;
   assign over = bus.level > SEGS_L;
   assign s    = over ? SEGS_L : bus.level;

   always_ff @(posedge clk) begin
      if (rst) begin
         lvl_q  <= '0;
         peak_q <= '0;
         hold_q <= '0;
         dec_q  <= '0;
         st_q   <= TRACK;
         clip_q <= 1'b0;
      end else begin
         lvl_q  <= lvl_d;
         peak_q <= peak_d;
         hold_q <= hold_d;
         dec_q  <= dec_d;
         st_q   <= st_d;
         clip_q <= clip_d;
      end
   end

   always_comb begin
      lvl_d  = lvl_q;
      peak_d = peak_q;
      hold_d = hold_q;
      dec_d  = dec_q;
      st_d   = st_q;
      clip_d = cap & over;
      if (bus.en) begin
         if (cap) lvl_d = s;
         if (cap && s >= peak_q) begin
            peak_d = s;
            hold_d = HOLD_LD;
            st_d   = HOLD;
         end else begin
            unique case (st_q)
               TRACK: begin
                  if (cap) begin
                     hold_d = HOLD_LD;
                     st_d   = HOLD;
                  end
               end
               HOLD: begin
                  if (hold_q == '0) begin
                     dec_d = DEC_LD;
                     st_d  = DECAY;
                  end else begin
                     hold_d = hold_q - 1'b1;
                  end
               end
               DECAY: begin
                  if (dec_q == '0) begin
                     dec_d = DEC_LD;
                     // peak-1 <= lvl, written without underflow
                     if ({1'b0, peak_q} <= {1'b0, lvl_d} + ONE) begin
                        peak_d = lvl_d;
                        st_d   = TRACK;
                     end else begin
                        peak_d = peak_q - 1'b1;
                     end
                  end else begin
                     dec_d = dec_q - 1'b1;
                  end
               end
               default: st_d = TRACK;
            endcase
         end
      end
   end

   thermo_decode #(.LEVEL_W(LEVEL_W), .SEGS(SEGS)) u_base (
      .lvl_i  (lvl_q),
      .mode_i (bus.mode),
      .mask_o (base_m)
   );

   thermo_decode #(.LEVEL_W(LEVEL_W), .SEGS(SEGS)) u_peak (
      .lvl_i  (peak_q),
      .mode_i (1'b1),
      .mask_o (peak_m)
   );

   assign bus.d_out = bus.en ? (base_m | peak_m) : '0;
   assign bus.peak  = peak_q;
   assign bus.clip  = clip_q & bus.en;

endmodule

// File: tb/tb_thermo_peak_meter.sv
// Bench: two meters (SEGS 7 and 5, hold 4, decay 2) vs age-based model.
// Directed scenarios with fixed expectations, then random stimulus.
module tb_thermo_peak_meter;

   localparam int H = 4;
   localparam int D = 2;

   logic       clk;
   logic       rst;
   logic       en, sv, mode;
   logic [2:0] lvl;

   int n_chk, n_err;
   int m_lvl[2], m_pk[2], m_age[2];
   bit m_trk[2], m_clip[2];
   int n, first, to2;

   thermo_peak_meter_if #(.LEVEL_W(3), .SEGS(7)) bus_a ();
   thermo_peak_meter_if #(.LEVEL_W(3), .SEGS(5)) bus_b ();

   assign bus_a.en           = en;
   assign bus_a.sample_valid = sv;
   assign bus_a.level        = lvl;
   assign bus_a.mode         = mode;
   assign bus_b.en           = en;
   assign bus_b.sample_valid = sv;
   assign bus_b.level        = lvl;
   assign bus_b.mode         = mode;

   thermo_peak_meter #(
      .LEVEL_W(3), .SEGS(7), .HOLD_CYC(H), .DECAY_CYC(D)
   ) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   thermo_peak_meter #(
      .LEVEL_W(3), .SEGS(5), .HOLD_CYC(H), .DECAY_CYC(D)
   ) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
      end
   endtask

   function automatic int segs_of(input int i);
      return (i == 0) ? 7 : 5;
   endfunction

   // Peak timing from edges elapsed since the last refresh.
   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         int sg;
         int s;
         sg = segs_of(i);
         s  = (int'(lvl) < sg) ? int'(lvl) : sg;
         if (rst) begin
            m_lvl[i] = 0; m_pk[i] = 0; m_age[i] = 0;
            m_trk[i] = 1; m_clip[i] = 0;
         end else if (!en) begin
            m_clip[i] = 0;
         end else begin
            m_clip[i] = sv && (int'(lvl) > sg);
            if (sv) m_lvl[i] = s;
            if (sv && s >= m_pk[i]) begin
               m_pk[i] = s; m_trk[i] = 0; m_age[i] = 0;
            end else if (m_trk[i]) begin
               if (sv) begin m_trk[i] = 0; m_age[i] = 0; end
            end else begin
               m_age[i]++;
               if (m_age[i] >= H + D && (m_age[i] - H) % D == 0) begin
                  if (m_pk[i] - 1 <= m_lvl[i]) begin
                     m_pk[i] = m_lvl[i]; m_trk[i] = 1;
                  end else begin
                     m_pk[i] = m_pk[i] - 1;
                  end
               end
            end
         end
      end
   endtask

   function automatic int model_dout(input int i);
      int r;
      r = 0;
      if (en) begin
         for (int b = 0; b < segs_of(i); b++) begin
            if ((mode ? (b == m_lvl[i] - 1) : (b < m_lvl[i]))
                || b == m_pk[i] - 1)
               r |= (1 << b);
         end
      end
      return r;
   endfunction

   task automatic compare_all();
      chk("a_dout", bus_a.d_out, model_dout(0));
      chk("a_peak", bus_a.peak, m_pk[0]);
      chk("a_clip", bus_a.clip, en && m_clip[0]);
      chk("b_dout", bus_b.d_out, model_dout(1));
      chk("b_peak", bus_b.peak, m_pk[1]);
      chk("b_clip", bus_b.clip, en && m_clip[1]);
   endtask

   task automatic step(input bit e, input bit v, input int l,
                       input bit m);
      en = e; sv = v; lvl = 3'(l); mode = m;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(0, 0, 0, 0);
      rst = 1'b0;
   endtask

   initial begin
      n_chk = 0; n_err = 0;
      rst = 1'b1; en = 0; sv = 0; lvl = 0; mode = 0;
      for (int i = 0; i < 2; i++) begin
         m_lvl[i] = 0; m_pk[i] = 0; m_age[i] = 0;
         m_trk[i] = 1; m_clip[i] = 0;
      end
      @(negedge clk);
      do_reset();
      en = 1;
      chk("rst_dout", bus_a.d_out, 0);
      chk("rst_peak", bus_a.peak, 0);
      chk("rst_clip", bus_a.clip, 0);

      step(1, 1, 5, 0);
      chk("s5_dout", bus_a.d_out, 7'b0011111);
      chk("s5_peak", bus_a.peak, 5);
      chk("s5_clip", bus_a.clip, 0);

      do_reset();
      step(1, 1, 6, 0);
      step(1, 1, 2, 0);
      chk("62_dout", bus_a.d_out, 7'b0100011);
      n = 1; first = -1; to2 = -1;
      for (int j = 0; j < 30; j++) begin
         step(1, 0, 0, 0);
         n++;
         if (first < 0 && bus_a.peak == 3'd5) first = n;
         if (to2 < 0 && bus_a.peak == 3'd2) to2 = n;
      end
      chk("first_dec", first, 6);
      chk("to_two", to2, 12);
      chk("track_dout", bus_a.d_out, 7'b0000011);

      do_reset();
      step(1, 1, 6, 0);
      step(1, 1, 3, 1);
      chk("dot_dout", bus_a.d_out, 7'b0100100);
      do_reset();
      step(1, 1, 0, 1);
      chk("dot0_dout", bus_a.d_out, 0);
      chk("dot0_peak", bus_a.peak, 0);

      do_reset();
      step(1, 1, 7, 0);
      chk("b_sat_dout", bus_b.d_out, 5'b11111);
      chk("b_sat_peak", bus_b.peak, 5);
      chk("b_clip_hi", bus_b.clip, 1);
      step(1, 0, 0, 0);
      chk("b_clip_lo", bus_b.clip, 0);

      do_reset();
      step(1, 1, 6, 0);
      step(1, 1, 2, 0);
      for (int j = 0; j < 7; j++) step(1, 0, 0, 0);
      chk("pre_off_peak", bus_a.peak, 4);
      for (int j = 0; j < 10; j++) step(0, 1, 7, 0);
      chk("off_dout", bus_a.d_out, 0);
      chk("off_peak", bus_a.peak, 4);
      step(1, 0, 0, 0);
      chk("resume1", bus_a.peak, 4);
      step(1, 0, 0, 0);
      chk("resume2", bus_a.peak, 3);

      do_reset();
      step(1, 1, 6, 0);
      step(1, 0, 0, 0);
      rst = 1'b1;
      step(1, 0, 0, 0);
      rst = 1'b0;
      chk("hrst_dout", bus_a.d_out, 0);
      chk("hrst_peak", bus_a.peak, 0);
      chk("hrst_clip", bus_a.clip, 0);
      step(1, 1, 1, 0);
      chk("hrst_one", bus_a.d_out, 7'b0000001);

      for (int j = 0; j < 600; j++) begin
         rst = ($urandom_range(99) < 2);
         step($urandom_range(9) < 8, $urandom_range(1) == 1,
              int'($urandom_range(7)), $urandom_range(1) == 1);
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/thermo_peak_meter.md
# thermo_peak_meter

Parametrised bar-graph level meter for the board LED row: a clocked, multi-mode successor to the 3-bit thermometer display. Captures a level sample, drives a SEGS-wide thermometer (bar) or single-dot pattern, and overlays a peak-hold marker. The marker holds for a programmable time, then decays one step at a time back to the current level. Sits between the sample source (ADC/switch logic) and the LED output pins.

## Interface
- LEVEL_W, 3: level input width.
- SEGS, 7: display segments; must satisfy 1 <= SEGS <= 2^LEVEL_W-1.
- HOLD_CYC, 8: cycles the peak is held after its last refresh; must be >= 1.
- DECAY_CYC, 4: cycles per one-step peak decrement; must be >= 1.
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  enable; low blanks d_out and freezes all state.
- sample_valid  in  1  level is captured on this edge when high (and en high).
- level  in  LEVEL_W  raw level sample.
- mode  in  1  0 = bar (thermometer), 1 = dot.
- d_out  out  SEGS  segment drive; bit 0 = lowest segment.
- peak  out  LEVEL_W  current peak-hold value (saturated).
- clip  out  1  high for one cycle after a sample with level > SEGS.

## Operation
- sat(x) = min(x, SEGS). All stored levels are saturated; lvl_q and peak_q never exceed SEGS.
- Capture: when en && sample_valid, lvl_q <= sat(level) and clip <= (level > SEGS). Otherwise clip <= 0.
- Display (combinational from registers): base = bits [lvl_q-1:0] set (mode 0) or bit lvl_q-1 only (mode 1); none if lvl_q = 0. Then OR in bit peak_q-1 when peak_q > 0. d_out = 0 whenever en = 0.
- Peak FSM states: TRACK (peak_q == lvl_q), HOLD, DECAY. Per enabled edge, first matching rule applies:
  - Captured sample s >= peak_q: peak_q <= s, hold_cnt <= HOLD_CYC-1, state <= HOLD.
  - TRACK with captured s < peak_q: hold_cnt <= HOLD_CYC-1, state <= HOLD; peak_q unchanged.
  - HOLD: if hold_cnt == 0 then decay_cnt <= DECAY_CYC-1, state <= DECAY; else hold_cnt decrements.
  - DECAY: if decay_cnt == 0 then peak_q <= peak_q-1, decay_cnt <= DECAY_CYC-1; if peak_q-1 <= lvl_q (new value when a sample is captured this edge) then peak_q <= that lvl_q and state <= TRACK. Otherwise decay_cnt decrements.
- Invariant: peak_q >= lvl_q at every edge.
- en low: no counter, FSM, or register changes; sample_valid ignored; clip forced 0.

## Timing
- Reset (rst high at an edge, overrides everything including en): lvl_q = 0, peak_q = 0, hold_cnt = 0, decay_cnt = 0, state = TRACK, clip = 0. Consequently d_out = 0 and peak = 0.
- Reset mid-hold or mid-decay returns to TRACK immediately; no residual marker.
- Latency: a sample captured at edge k is visible on d_out, peak, and clip after edge k (one cycle).
- A peak set at edge k with no further refresh: first decrement at edge k + HOLD_CYC + DECAY_CYC. Subsequent decrements every DECAY_CYC edges.
- A new sample equal to the peak during DECAY reloads HOLD and does not decrement.
- Back-to-back sample_valid every cycle is legal; there is no handshake and no stall.

## Structure
- Shared package thermo_pkg: FSM state encodings (TRACK = 2'd0, HOLD = 2'd1, DECAY = 2'd2) and a clog2 constant function for counter widths.
- Counter widths: clog2(HOLD_CYC) and clog2(DECAY_CYC), with a minimum of 1 bit.
- Sub-module thermo_decode: parametrised (LEVEL_W, SEGS) combinational level-to-mask decoder with mode input. Instantiate it twice: once for the base pattern and once as the dot-mode decoder for the peak marker.

## Test plan
All scenarios use defaults except HOLD_CYC = 4, DECAY_CYC = 2.
- Reset, then a sample with level = 5, mode 0: next cycle d_out = 7'b0011111 and peak = 5; clip = 0.
- Capture 6, then capture 2: d_out = 7'b0100011. The first peak decrement lands exactly 4+2 edges after the 6. Peak then steps 6→5→4→3→2 every 2 cycles and ends in TRACK with d_out = 7'b0000011.
- Mode 1 with lvl 3 and peak 6: d_out = 7'b0100100. With level = 0 and peak = 0: d_out = 0.
- Capture level = 7 on SEGS = 5 (LEVEL_W = 3): lvl_q = 5, peak = 5, clip high for exactly one cycle, d_out = 5'b11111.
- Mid-DECAY (peak = 4), drop en for 10 cycles: d_out = 0 and peak stays 4. Raise en: decay resumes with the same decay_cnt.
- Assert rst in HOLD with peak = 6: the next cycle shows all outputs 0. A subsequent capture of 1 gives d_out = 7'b0000001.
